// File: rtl/car_disp_pkg.sv
// ============================================================================
// car_disp_pkg : shared constants for the car-status mileage display
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package car_disp_pkg;

    localparam int MILE_W     = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Segment order a,b,c,d,e,f,g,dp from MSB to LSB; dp is never lit
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble, 16-bit binary to 5 BCD digits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import car_disp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MILE_W-1:0] bin_i,
    output logic [BCD_W-1:0]  bcd_o,
    output logic              done_o
);

    logic [1:0]        state_q, state_d;
    logic [MILE_W-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0]  acc_q,   acc_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [BCD_W-1:0]  bcd_q,   bcd_d;
    logic              done_q,  done_d;
    logic [BCD_W-1:0]  w_acc_adj;

    genvar k;
    generate
        for (k = 0; k < BCD_DIGITS; k++) begin : g_adj
            assign w_acc_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ?
                                         acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bin_d   = bin_i;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {acc_d, bin_d} = {w_acc_adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only place the visible result changes, so no partial value leaks out
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/mileage_display.sv
// ============================================================================
// mileage_display : odometer BCD conversion and 8-digit 7-segment scan
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module mileage_display
    import car_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int NUM_POS  = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MILE_W-1:0]  mile_i,
    input  logic               enable_i,
    output logic [NUM_POS-1:0] seg_en_o,
    output logic [7:0]         seg_out_o,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               conv_done_o
);

    localparam int              c_CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_SCAN_TERM = c_CNT_W'(SCAN_DIV - 1);

    logic [BCD_W-1:0]   w_bcd;
    logic               w_done;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [NUM_POS-1:0] seg_en_q, seg_en_d;
    logic [7:0]         seg_out_q, seg_out_d;
    logic [3:0]         w_dig [BCD_DIGITS];
    logic [BCD_DIGITS-1:0] w_lz;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic               w_valid;

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .bin_i  (mile_i),
        .bcd_o  (w_bcd),
        .done_o (w_done)
    );

    // Digit k is blanked when it and every more-significant digit is zero
    genvar k;
    generate
        for (k = 0; k < BCD_DIGITS; k++) begin : g_digit
            assign w_dig[k] = w_bcd[4*k +: 4];
            if (k == 0) begin : g_units
                assign w_lz[k] = 1'b0;
            end else begin : g_upper
                assign w_lz[k] = ~|w_bcd[BCD_W-1:4*k];
            end
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + c_CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == c_SCAN_TERM) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
        w_nib   = '0;
        w_blank = 1'b0;
        w_valid = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                w_nib   = w_dig[i];
                w_blank = w_lz[i];
                w_valid = 1'b1;
            end
        end
        seg_en_d  = (enable_i && w_valid) ? (NUM_POS'(1) << idx_q) : '0;
        seg_out_d = (enable_i && w_valid && !w_blank) ? seg_encode(w_nib) : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_en_q  <= '0;
            seg_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign seg_en_o    = seg_en_q;
    assign seg_out_o   = seg_out_q;
    assign bcd_o       = w_bcd;
    assign conv_done_o = w_done;

endmodule

`default_nettype wire

// File: tb/tb_mileage_display.sv
// ============================================================================
// tb_mileage_display : directed self-checking bench for mileage_display
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mileage_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] mile;
    logic        enable;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic [19:0] bcd;
    logic        conv_done;

    int total = 0;
    int bad   = 0;

    mileage_display #(.SCAN_DIV(4), .NUM_POS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mile_i      (mile),
        .enable_i    (enable),
        .seg_en_o    (seg_en),
        .seg_out_o   (seg_out),
        .bcd_o       (bcd),
        .conv_done_o (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (conv_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (seg_en === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic scan_chk(input string tag, input logic [7:0] en, input logic [7:0] pat);
        bit ok;
        wait_en(en, ok);
        chk({tag, "_en_seen"}, 32'(ok), 32'd1);
        chk({tag, "_seg"}, 32'(seg_out), 32'(pat));
    endtask

    task automatic convert(input logic [15:0] m);
        bit ok1, ok2;
        mile = m;
        wait_done(ok1);
        wait_done(ok2);
        chk("conv_timeout", 32'(ok1 & ok2), 32'd1);
    endtask

    initial begin
        bit ok;
        int edges;
        int first_done, second_done;
        bit dark_ok;
        int illegal;
        int ndone;

        rst_n  = 1'b0;
        mile   = 16'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_seg_en", 32'(seg_en), 32'h0);
        chk("rst_seg_out", 32'(seg_out), 32'h0);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_done", 32'(conv_done), 32'h0);

        // First edge after release latches; done lands on the 18th edge
        rst_n = 1'b1;
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (conv_done === 1'b1) begin
                edges = n;
                break;
            end
        end
        chk("first_done_edge", 32'(edges), 32'd18);
        @(negedge clk);
        chk("done_one_cycle", 32'(conv_done), 32'd0);
        chk("bcd_zero", 32'(bcd), 32'h00000);
        scan_chk("m0_p0", 8'h01, 8'hFC);
        scan_chk("m0_p1", 8'h02, 8'h00);
        scan_chk("m0_p4", 8'h10, 8'h00);

        convert(16'd12345);
        chk("bcd_12345", 32'(bcd), 32'h12345);
        scan_chk("m12345_p0", 8'h01, 8'hB6);
        scan_chk("m12345_p1", 8'h02, 8'h66);
        scan_chk("m12345_p2", 8'h04, 8'hF2);
        scan_chk("m12345_p3", 8'h08, 8'hDA);
        scan_chk("m12345_p4", 8'h10, 8'h60);
        repeat (4) @(negedge clk);
        chk("m12345_p5_en", 32'(seg_en), 32'h0);
        chk("m12345_p5_seg", 32'(seg_out), 32'h0);
        repeat (4) @(negedge clk);
        chk("m12345_p6_en", 32'(seg_en), 32'h0);
        repeat (4) @(negedge clk);
        chk("m12345_p7_en", 32'(seg_en), 32'h0);
        chk("m12345_p7_seg", 32'(seg_out), 32'h0);

        convert(16'd65535);
        chk("bcd_65535", 32'(bcd), 32'h65535);
        scan_chk("m65535_p0", 8'h01, 8'hB6);
        scan_chk("m65535_p1", 8'h02, 8'hF2);
        scan_chk("m65535_p2", 8'h04, 8'hB6);
        scan_chk("m65535_p3", 8'h08, 8'hB6);
        scan_chk("m65535_p4", 8'h10, 8'hBE);
        repeat (16) @(negedge clk);
        chk("m65535_wrap_en", 32'(seg_en), 32'h01);
        chk("m65535_wrap_seg", 32'(seg_out), 32'hB6);

        convert(16'd7);
        chk("bcd_7", 32'(bcd), 32'h00007);
        scan_chk("m7_p0", 8'h01, 8'hE0);
        scan_chk("m7_p1", 8'h02, 8'h00);
        scan_chk("m7_p2", 8'h04, 8'h00);
        scan_chk("m7_p3", 8'h08, 8'h00);
        scan_chk("m7_p4", 8'h10, 8'h00);

        // Latch 100, then change to 200 two cycles into the conversion
        wait_done(ok);
        chk("sync_done", 32'(ok), 32'd1);
        mile = 16'd100;
        repeat (3) @(negedge clk);
        mile = 16'd200;
        illegal = 0;
        ndone   = 0;
        for (int n = 0; n < 60 && ndone < 2; n++) begin
            @(negedge clk);
            if (bcd !== 20'h00007 && bcd !== 20'h00100 && bcd !== 20'h00200) illegal++;
            if (conv_done === 1'b1) begin
                ndone++;
                if (ndone == 1) chk("bcd_after_100", 32'(bcd), 32'h00100);
                else            chk("bcd_after_200", 32'(bcd), 32'h00200);
            end
        end
        chk("midconv_done_count", 32'(ndone), 32'd2);
        chk("no_partial_bcd", 32'(illegal), 32'd0);

        enable = 1'b0;
        @(negedge clk);
        chk("dis_seg_en", 32'(seg_en), 32'h0);
        chk("dis_seg_out", 32'(seg_out), 32'h0);
        dark_ok     = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (seg_en !== 8'h0 || seg_out !== 8'h0) dark_ok = 1'b0;
            if (conv_done === 1'b1) begin
                if (first_done < 0)       first_done  = n;
                else if (second_done < 0) second_done = n;
            end
        end
        chk("dis_dark", 32'(dark_ok), 32'd1);
        chk("dis_done_seen", 32'((first_done >= 0) && (second_done >= 0)), 32'd1);
        chk("dis_done_period", 32'(second_done - first_done), 32'd18);
        enable = 1'b1;

        wait_done(ok);
        chk("pre_rst_done", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg_en", 32'(seg_en), 32'h0);
        chk("async_seg_out", 32'(seg_out), 32'h0);
        chk("async_bcd", 32'(bcd), 32'h0);
        chk("async_done", 32'(conv_done), 32'h0);
        mile = 16'd4321;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(ok);
        chk("post_rst_done", 32'(ok), 32'd1);
        chk("post_rst_bcd", 32'(bcd), 32'h04321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
